// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// The state enum, opcode values, datapath mux encodings and the packed control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    WB_R   = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_MEM = 4'd7,
    BEQ    = 4'd8,
    BNE    = 4'd9,
    JUMP   = 4'd10
  } state_t;

  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_LW    = 4;
  localparam int OP_SW    = 5;
  localparam int OP_BEQ   = 6;
  localparam int OP_BNE   = 7;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB_EQ = 2'b01;
  localparam logic [1:0] ALU_SUB_NE = 2'b10;
  localparam logic [1:0] ALU_FUNCT  = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_ne;
    logic       pc_write_eq;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

  // States in which the memory port is busy and mem_ready is awaited.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the wait budget is used up.
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = 8'd0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign expired = (wait_cnt_q == 8'(WAIT_MAX));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: one datapath phase per cycle, handshaken memory port with
// a bounded wait, illegal opcodes flagged and skipped.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_ne,
  output logic            pc_write_eq,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op,
  output logic            mem_err
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctl_s;
  logic   waiting_s;
  logic   expired_s;
  logic   timeout_s;

  assign waiting_s = is_mem_state(state_q) && !mem_ready;
  assign timeout_s = waiting_s && expired_s;

  // A completed, timed-out or abandoned access restarts the wait budget.
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting_s),
    .clear   (!waiting_s || timeout_s),
    .expired (expired_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (op == OP_W'(OP_RTYPE))                          state_d = EXEC_R;
        else if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW))  state_d = ADDR;
        else if (op == OP_W'(OP_BEQ))                       state_d = BEQ;
        else if (op == OP_W'(OP_BNE))                       state_d = BNE;
        else if (op == OP_W'(OP_J))                         state_d = JUMP;
        else                                                state_d = FETCH;
      end
      EXEC_R: state_d = WB_R;
      ADDR: begin
        if (op == OP_W'(OP_LW))      state_d = MEM_RD;
        else if (op == OP_W'(OP_SW)) state_d = MEM_WR;
        else                         state_d = FETCH;
      end
      MEM_RD: begin
        if (mem_ready)      state_d = WB_MEM;
        else if (timeout_s) state_d = FETCH;
        else                state_d = MEM_RD;
      end
      MEM_WR: begin
        if (mem_ready || timeout_s) state_d = FETCH;
        else                        state_d = MEM_WR;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces every control line low, even mid-access.
  always_comb begin
    ctl_s = '0;
    case (state_q)
      FETCH: begin
        ctl_s.mem_read  = 1'b1;
        ctl_s.alu_src_b = SRCB_FOUR;
        ctl_s.ir_write  = mem_ready;
        ctl_s.pc_write  = mem_ready;
      end
      DECODE: begin
        ctl_s.alu_src_b  = SRCB_IMM_SH2;
        ctl_s.illegal_op = (state_d == FETCH);
      end
      EXEC_R: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_op    = ALU_FUNCT;
      end
      WB_R: begin
        ctl_s.reg_dst   = 1'b1;
        ctl_s.reg_write = 1'b1;
      end
      ADDR: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        ctl_s.mem_read = 1'b1;
        ctl_s.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        ctl_s.mem_write = 1'b1;
        ctl_s.i_or_d    = 1'b1;
      end
      WB_MEM: begin
        ctl_s.reg_write  = 1'b1;
        ctl_s.mem_to_reg = 1'b1;
      end
      BEQ: begin
        ctl_s.alu_src_a   = 1'b1;
        ctl_s.alu_op      = ALU_SUB_EQ;
        ctl_s.pc_write_eq = 1'b1;
        ctl_s.pc_source   = PCSRC_ALUOUT;
      end
      BNE: begin
        ctl_s.alu_src_a   = 1'b1;
        ctl_s.alu_op      = ALU_SUB_NE;
        ctl_s.pc_write_ne = 1'b1;
        ctl_s.pc_source   = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctl_s.pc_write  = 1'b1;
        ctl_s.pc_source = PCSRC_JUMP;
      end
      default: ctl_s = '0;
    endcase
    ctl_s.mem_err = timeout_s;
    if (!rst_n) begin
      ctl_s = '0;
    end else begin
      ctl_s.mem_err = timeout_s;
    end
  end

  assign pc_write    = ctl_s.pc_write;
  assign pc_write_ne = ctl_s.pc_write_ne;
  assign pc_write_eq = ctl_s.pc_write_eq;
  assign i_or_d      = ctl_s.i_or_d;
  assign mem_read    = ctl_s.mem_read;
  assign mem_write   = ctl_s.mem_write;
  assign ir_write    = ctl_s.ir_write;
  assign reg_dst     = ctl_s.reg_dst;
  assign mem_to_reg  = ctl_s.mem_to_reg;
  assign reg_write   = ctl_s.reg_write;
  assign alu_src_a   = ctl_s.alu_src_a;
  assign alu_src_b   = ctl_s.alu_src_b;
  assign alu_op      = ctl_s.alu_op;
  assign pc_source   = ctl_s.pc_source;
  assign illegal_op  = ctl_s.illegal_op;
  assign mem_err     = ctl_s.mem_err;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level model expands each instruction into per-cycle
// stimulus and expected control words; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int WMAX = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] op;
  logic       pc_write, pc_write_ne, pc_write_eq, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_source;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_ne;
    logic       pc_write_eq;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_err;
  } vec_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [5:0] opc;
    vec_t       exp;
  } step_t;

  step_t steps[$];
  vec_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  vec_t  act;

  multicycle_control #(.OP_W(6), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_ne(pc_write_ne), .pc_write_eq(pc_write_eq),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_ne, pc_write_eq, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                illegal_op, mem_err};

  function automatic logic is_legal(input logic [5:0] o);
    return (o == 6'd0) || (o == 6'd2) || (o == 6'd4) || (o == 6'd5) || (o == 6'd6) || (o == 6'd7);
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  task automatic add(input logic rst, input logic rdy, input logic [5:0] o, input vec_t e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.opc = o; s.exp = e;
    steps.push_back(s);
  endtask

  task automatic add_any(input logic [5:0] o, input vec_t e);
    add(1'b1, 1'($urandom), o, e);
  endtask

  // A memory access: wait_n not-ready cycles then ready, aborted once the budget is gone.
  task automatic mem_access(input int wait_n, input vec_t waitv, input vec_t donev, output logic ok);
    vec_t e;
    for (int k = 0; k < wait_n && k <= WMAX; k++) begin
      e = waitv;
      e.mem_err = (k == WMAX);
      add(1'b1, 1'b0, junk(), e);
    end
    ok = (wait_n <= WMAX);
    if (ok) add(1'b1, 1'b1, junk(), donev);
  endtask

  task automatic run_instr(input logic [5:0] opc, input int fwait, input int mwait, input logic rst_in_wr);
    vec_t w, d, e;
    logic ok;
    int   fw;
    fw = fwait;
    w = '0; w.mem_read = 1'b1; w.alu_src_b = 2'b01;
    d = w;  d.ir_write = 1'b1; d.pc_write = 1'b1;
    do begin
      mem_access(fw, w, d, ok);
      fw = 0;
    end while (!ok);
    e = '0; e.alu_src_b = 2'b11; e.illegal_op = !is_legal(opc);
    add_any(opc, e);
    if (!is_legal(opc)) return;
    e = '0;
    case (opc)
      6'd0: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b11; add_any(junk(), e);
        e = '0; e.reg_dst = 1'b1; e.reg_write = 1'b1; add_any(junk(), e);
      end
      6'd4, 6'd5: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; add_any(opc, e);
        if (opc == 6'd5 && rst_in_wr) begin
          add(1'b0, 1'($urandom), junk(), '0);
        end else begin
          w = '0; w.i_or_d = 1'b1;
          if (opc == 6'd4) w.mem_read = 1'b1; else w.mem_write = 1'b1;
          mem_access(mwait, w, w, ok);
          if (ok && opc == 6'd4) begin
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; add_any(junk(), e);
          end
        end
      end
      6'd6: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_eq = 1'b1; e.pc_source = 2'b01;
        add_any(junk(), e);
      end
      6'd7: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b10; e.pc_write_ne = 1'b1; e.pc_source = 2'b01;
        add_any(junk(), e);
      end
      default: begin
        e.pc_write = 1'b1; e.pc_source = 2'b10; add_any(junk(), e);
      end
    endcase
  endtask

  // Monitor: every cycle with a pending expectation is compared against the DUT.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t exp_v;
      exp_v = sb.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL ctl_vec cycle %0d: got %05h expected %05h", cyc, act, exp_v);
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] o;
    rst_n = 1'b0; mem_ready = 1'b0; op = 6'd0;
    ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'h3F, 6'h01};

    for (int i = 0; i < 3; i++) add(1'b0, 1'($urandom), junk(), '0);
    run_instr(6'd0, 0, 0, 1'b0);
    run_instr(6'd4, 0, 3, 1'b0);
    run_instr(6'd5, 0, 0, 1'b0);
    run_instr(6'd7, 0, 0, 1'b0);
    run_instr(6'h3F, 0, 0, 1'b0);
    run_instr(6'd0, 4, 0, 1'b0);
    run_instr(6'd2, 3, 0, 1'b0);
    run_instr(6'd5, 0, 0, 1'b1);
    run_instr(6'd4, 0, 5, 1'b0);
    run_instr(6'd5, 0, 4, 1'b0);
    run_instr(6'd6, 1, 2, 1'b0);
    for (int i = 0; i < 150; i++) begin
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) o = junk();
      run_instr(o, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                ($urandom_range(0, 15) == 0));
    end

    foreach (steps[i]) begin
      @(posedge clk);
      #1;
      cyc       = i;
      rst_n     = steps[i].rst;
      mem_ready = steps[i].rdy;
      op        = steps[i].opc;
      sb.push_back(steps[i].exp);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
